// File: rtl/fetch_decode_skid_buffer_if.sv
// Handshake bundle between instruction fetch and instruction decode.
// The fetch side (and anything standing in for it) uses the master modport.
// The skid buffer uses the slave modport. dbg_state exposes the buffer FSM
// state so that checkers can bind to it without reaching into the design.
interface fetch_decode_skid_buffer_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32
);
  // Control
  logic                   flush;

  // Fetch side
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] in_instruction;
  logic [ADDR_WIDTH-1:0]  in_next_address;

  // Decode side
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH-1:0]  out_next_address;

  // Status
  logic [1:0]             occupancy;
  logic [1:0]             dbg_state;

  modport master (
    output flush,
    output in_valid,
    output in_instruction,
    output in_next_address,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instruction,
    input  out_next_address,
    input  occupancy,
    input  dbg_state
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_instruction,
    input  in_next_address,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instruction,
    output out_next_address,
    output occupancy,
    output dbg_state
  );
endinterface

// File: rtl/fetch_decode_skid_buffer.sv
// Fetch/decode pipeline boundary with a two-entry skid buffer.
//
// Handshake: a beat moves on a rising clock edge when valid and ready are
// both high on that side (push = in_valid & in_ready, pop = out_valid &
// out_ready). valid never waits for ready; once out_valid is high the
// presented entry stays stable until it is popped or flushed. in_ready is a
// register computed from the next state, so it never depends combinationally
// on out_ready.
//
// The main register always holds the oldest entry and drives out_*; the skid
// register catches the one extra beat that can arrive in the cycle in_ready
// is still high while decode stalls. flush clears both entries and drops the
// same-cycle input.
module fetch_decode_skid_buffer #(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fetch_decode_skid_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   in_ready_q;
  logic                   in_ready_d;
  logic [INSTR_WIDTH-1:0] main_instr_q;
  logic [INSTR_WIDTH-1:0] main_instr_d;
  logic [ADDR_WIDTH-1:0]  main_addr_q;
  logic [ADDR_WIDTH-1:0]  main_addr_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q;
  logic [INSTR_WIDTH-1:0] skid_instr_d;
  logic [ADDR_WIDTH-1:0]  skid_addr_q;
  logic [ADDR_WIDTH-1:0]  skid_addr_d;

  logic                   out_valid;
  logic                   push;
  logic                   pop;

  // Decode sees a valid entry whenever the main register is occupied.
  assign out_valid = (state_q != ST_EMPTY);

  // Transfer qualifiers; push can only happen while in_ready_q is high.
  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid & bus.out_ready;

  // Next-state, in_ready and data-register update selection.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_addr_d  = main_addr_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;

    if (bus.flush) begin
      // Wrong-path work: drop everything, including this cycle's input.
      // A pop in this cycle already handed out_* to decode.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d      = ST_ONE;
            main_instr_d = bus.in_instruction;
            main_addr_d  = bus.in_next_address;
          end
        end

        ST_ONE: begin
          if (push && pop) begin
            // Replace the consumed entry directly: no bubble.
            state_d      = ST_ONE;
            main_instr_d = bus.in_instruction;
            main_addr_d  = bus.in_next_address;
          end else if (push) begin
            // Decode stalled: park the new beat behind the main entry.
            state_d      = ST_TWO;
            skid_instr_d = bus.in_instruction;
            skid_addr_d  = bus.in_next_address;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end

        ST_TWO: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_d      = ST_ONE;
            main_instr_d = skid_instr_q;
            main_addr_d  = skid_addr_q;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // State and in_ready registers; reset leaves the buffer empty and ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Main and skid data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_instr_q <= '0;
      main_addr_q  <= '0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
    end else begin
      main_instr_q <= main_instr_d;
      main_addr_q  <= main_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
    end
  end

  // Outputs: an empty buffer presents a NOP and a zero address.
  always_comb begin
    bus.in_ready         = in_ready_q;
    bus.out_valid        = out_valid;
    bus.out_instruction  = out_valid ? main_instr_q : NOP_WORD;
    bus.out_next_address = out_valid ? main_addr_q : '0;
    bus.dbg_state        = state_q;
    unique case (state_q)
      ST_EMPTY: bus.occupancy = 2'd0;
      ST_ONE:   bus.occupancy = 2'd1;
      ST_TWO:   bus.occupancy = 2'd2;
      default:  bus.occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_skid_buffer.sv
// Testbench for fetch_decode_skid_buffer: directed vector table, hand-written
// reset/flush sequences and a long random run against a reference FIFO.
module tb_fetch_decode_skid_buffer;

  localparam int IW = 32;
  localparam int AW = 32;
  localparam int NV = 19;
  localparam int N_RAND = 12000;

  logic clk;
  logic reset_n;

  fetch_decode_skid_buffer_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  fetch_decode_skid_buffer #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  typedef struct {
    logic          flush;
    logic          iv;
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
    logic          ordy;
    logic          e_ov;
    logic          e_ir;
    logic [1:0]    e_occ;
    logic [IW-1:0] e_instr;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[NV];

  logic [IW-1:0] exp_q[$];
  logic [AW-1:0] exp_a[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic fl, input logic iv, input logic [31:0] ins,
                         input logic [31:0] ad, input logic ordy, input logic e_ov,
                         input logic e_ir, input logic [1:0] e_occ,
                         input logic [31:0] e_ins, input logic [31:0] e_ad);
    vecs[i].flush   = fl;
    vecs[i].iv      = iv;
    vecs[i].instr   = ins;
    vecs[i].addr    = ad;
    vecs[i].ordy    = ordy;
    vecs[i].e_ov    = e_ov;
    vecs[i].e_ir    = e_ir;
    vecs[i].e_occ   = e_occ;
    vecs[i].e_instr = e_ins;
    vecs[i].e_addr  = e_ad;
  endtask

  // Driver: apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic fl, input logic iv, input logic [31:0] ins,
                       input logic [31:0] ad, input logic ordy);
    bus.flush           = fl;
    bus.in_valid        = iv;
    bus.in_instruction  = ins;
    bus.in_next_address = ad;
    bus.out_ready       = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic ov, input logic ir,
                               input logic [1:0] occ, input logic [31:0] ins,
                               input logic [31:0] ad);
    check({tag, ".out_valid"},        {31'd0, bus.out_valid}, {31'd0, ov});
    check({tag, ".in_ready"},         {31'd0, bus.in_ready},  {31'd0, ir});
    check({tag, ".occupancy"},        {30'd0, bus.occupancy}, {30'd0, occ});
    check({tag, ".out_instruction"},  bus.out_instruction,    ins);
    check({tag, ".out_next_address"}, bus.out_next_address,   ad);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // Expected values are the outputs seen after the clock edge that
    // consumed the row's inputs.
    //          fl  iv  instr          addr          ordy ov ir occ  out_instr      out_addr
    // streaming
    set_vec(0,  0, 1, 32'h2008_0001, 32'h0000_0004, 1,  1, 1, 1, 32'h2008_0001, 32'h0000_0004);
    set_vec(1,  0, 1, 32'h2009_0002, 32'h0000_0008, 1,  1, 1, 1, 32'h2009_0002, 32'h0000_0008);
    set_vec(2,  0, 1, 32'h0109_5020, 32'h0000_000C, 1,  1, 1, 1, 32'h0109_5020, 32'h0000_000C);
    set_vec(3,  0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    // backpressure
    set_vec(4,  0, 1, 32'h8C08_0004, 32'h0000_0004, 0,  1, 1, 1, 32'h8C08_0004, 32'h0000_0004);
    set_vec(5,  0, 1, 32'hAC09_0008, 32'h0000_0008, 0,  1, 0, 2, 32'h8C08_0004, 32'h0000_0004);
    set_vec(6,  0, 1, 32'hDEAD_BEEF, 32'h0000_0099, 0,  1, 0, 2, 32'h8C08_0004, 32'h0000_0004);
    set_vec(7,  0, 0, 32'h0000_0000, 32'h0000_0000, 1,  1, 1, 1, 32'hAC09_0008, 32'h0000_0008);
    set_vec(8,  0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    // simultaneous push/pop in ONE
    set_vec(9,  0, 1, 32'h0000_0020, 32'h0000_0010, 0,  1, 1, 1, 32'h0000_0020, 32'h0000_0010);
    set_vec(10, 0, 1, 32'h2210_0001, 32'h0000_0014, 1,  1, 1, 1, 32'h2210_0001, 32'h0000_0014);
    set_vec(11, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    // flush from TWO with an offered input
    set_vec(12, 0, 1, 32'h1111_0001, 32'h0000_0020, 0,  1, 1, 1, 32'h1111_0001, 32'h0000_0020);
    set_vec(13, 0, 1, 32'h1111_0002, 32'h0000_0024, 0,  1, 0, 2, 32'h1111_0001, 32'h0000_0020);
    set_vec(14, 1, 1, 32'h1000_FFFF, 32'h0000_0028, 0,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    set_vec(15, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    // flush from ONE with in_ready high, pop and input in the same cycle
    set_vec(16, 0, 1, 32'h3000_0001, 32'h0000_0030, 0,  1, 1, 1, 32'h3000_0001, 32'h0000_0030);
    set_vec(17, 1, 1, 32'h1000_FFFF, 32'h0000_0034, 1,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    set_vec(18, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 1, 0, 32'h0000_0000, 32'h0000_0000);

    reset_n             = 1'b0;
    bus.flush           = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_instruction  = '0;
    bus.in_next_address = '0;
    bus.out_ready       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].flush, vecs[i].iv, vecs[i].instr, vecs[i].addr, vecs[i].ordy);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ,
                    vecs[i].e_instr, vecs[i].e_addr);
    end

    // Asynchronous reset with two entries held
    drive(1'b0, 1'b1, 32'h5555_0001, 32'h0000_0040, 1'b0);
    drive(1'b0, 1'b1, 32'h5555_0002, 32'h0000_0044, 1'b0);
    check({"pre_reset", ".occupancy"}, {30'd0, bus.occupancy}, 32'd2);
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    // Pushes and flush while reset is held have no effect
    drive(1'b1, 1'b1, 32'h6666_0001, 32'h0000_0050, 1'b1);
    check_outputs("reset_held", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outputs("post_reset", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);

    // Random valid/ready/flush against a reference FIFO
    exp_q.delete();
    exp_a.delete();
    for (int c = 0; c < N_RAND; c++) begin
      logic          fl;
      logic          iv;
      logic          ordy;
      logic [IW-1:0] ins;
      logic [AW-1:0] ad;
      logic          m_push;
      logic          m_pop;
      fl   = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      ins  = $urandom;
      ad   = 32'(c) << 2;
      m_push = iv && (exp_q.size() < 2);
      m_pop  = ordy && (exp_q.size() > 0);
      drive(fl, iv, ins, ad, ordy);
      if (fl) begin
        exp_q.delete();
        exp_a.delete();
      end else begin
        if (m_pop) begin
          void'(exp_q.pop_front());
          void'(exp_a.pop_front());
        end
        if (m_push) begin
          exp_q.push_back(ins);
          exp_a.push_back(ad);
        end
      end
      if (exp_q.size() > 0)
        check_outputs("rand", 1'b1, exp_q.size() < 2, 2'(exp_q.size()), exp_q[0], exp_a[0]);
      else
        check_outputs("rand", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
